// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: valid/ready bus master with byte strobes,
// store lane replication and load extract/extend.
module lsu_mem_ctrl #(
  parameter int ISA_WIDTH = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 mem_r_en,
  input  logic                 mem_w_en,
  input  logic [ISA_WIDTH-1:0] mem_addr,
  input  logic [ISA_WIDTH-1:0] mem_w,
  input  logic [1:0]           mem_size,
  input  logic                 mem_unsigned,
  output logic                 resp_valid,
  output logic [ISA_WIDTH-1:0] mem_r,
  output logic                 resp_err,
  output logic                 bus_req_valid,
  input  logic                 bus_req_ready,
  output logic                 bus_we,
  output logic [ISA_WIDTH-1:0] bus_addr,
  output logic [ISA_WIDTH-1:0] bus_wdata,
  output logic [3:0]           bus_wstrb,
  input  logic                 bus_resp_valid,
  input  logic [ISA_WIDTH-1:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE, REQ, WAIT, RESP
  } state_e;

  localparam logic [7:0] TO = 8'(TIMEOUT);

  state_e               state_q, state_d;
  logic [7:0]           cnt_q;
  logic [ISA_WIDTH-1:0] addr_q, wdata_q;
  logic [3:0]           strb_q;
  logic                 we_q, uns_q;
  logic [1:0]           size_q, off_q;
  logic [ISA_WIDTH-1:0] r_q, r_d;
  logic                 err_q, err_d;

  logic                 accept, any_en;
  logic                 misal, tmo;
  logic [ISA_WIDTH-1:0] acc_wdata;
  logic [3:0]           acc_strb;
  logic [ISA_WIDTH-1:0] lane, ext;

  assign accept = (state_q == IDLE) && req_valid;
  assign any_en = mem_r_en | mem_w_en;
  assign tmo    = (cnt_q == TO);

  always_comb begin
    misal = 1'b0;
    unique case (mem_size)
      2'd0: misal = 1'b0;
      2'd1: misal = mem_addr[0];
      2'd2: misal = (mem_addr[1:0] != 2'b00);
      default: misal = 1'b1;
    endcase
  end

  always_comb begin
    acc_wdata = mem_w;
    acc_strb  = 4'hF;
    unique case (mem_size)
      2'd0: begin
        acc_wdata = {4{mem_w[7:0]}};
        acc_strb  = 4'b0001 << mem_addr[1:0];
      end
      2'd1: begin
        acc_wdata = {2{mem_w[15:0]}};
        acc_strb  = 4'b0011 << mem_addr[1:0];
      end
      default: begin
        acc_wdata = mem_w;
        acc_strb  = 4'hF;
      end
    endcase
  end

  assign lane = bus_rdata >> {off_q, 3'b000};

  always_comb begin
    ext = bus_rdata;
    unique case (1'b1)
      (size_q == 2'd0):
        ext = {{(ISA_WIDTH-8){lane[7] & ~uns_q}},
               lane[7:0]};
      (size_q == 2'd1):
        ext = {{(ISA_WIDTH-16){lane[15] & ~uns_q}},
               lane[15:0]};
      default:
        ext = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    r_d     = '0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: if (req_valid) begin
        if (!any_en) begin
          state_d = RESP;
        end else if (misal) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else begin
          state_d = REQ;
        end
      end
      REQ: if (bus_req_ready) begin
        state_d = WAIT;
      end else if (tmo) begin
        state_d = RESP;
        err_d   = 1'b1;
      end
      WAIT: if (bus_resp_valid) begin
        state_d = RESP;
        r_d     = we_q ? '0 : ext;
      end else if (tmo) begin
        state_d = RESP;
        err_d   = 1'b1;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= '0;
      off_q   <= '0;
      r_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      r_q   <= r_d;
      err_q <= err_d;
      if (accept) begin
        cnt_q   <= '0;
        addr_q  <= {mem_addr[ISA_WIDTH-1:2], 2'b00};
        wdata_q <= mem_w_en ? acc_wdata : '0;
        strb_q  <= mem_w_en ? acc_strb : 4'h0;
        we_q    <= mem_w_en;
        uns_q   <= mem_unsigned;
        size_q  <= mem_size;
        off_q   <= mem_addr[1:0];
      end else if (state_q == REQ || state_q == WAIT) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    req_ready     = (state_q == IDLE);
    bus_req_valid = (state_q == REQ);
    resp_valid    = (state_q == RESP);
    bus_we        = bus_req_valid & we_q;
    bus_addr      = bus_req_valid ? addr_q : '0;
    bus_wdata     = bus_req_valid ? wdata_q : '0;
    bus_wstrb     = bus_req_valid ? strb_q : 4'h0;
    mem_r         = r_q;
    resp_err      = err_q;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store unit sitting directly downstream of the execute-stage memory-request logic.
- Accepts one memory request per handshake: address, write data, read/write enable and access size.
- Drives a simple valid/ready request/response bus to data memory, generates byte strobes, and aligns and extends load data.
- Returns load data and an alignment-error flag to writeback.

Parameters:
- ISA_WIDTH, 32, data and address width; only 32 is supported.
- TIMEOUT, 255, bus cycles to wait for a response before flagging an error; 8-bit counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  request from execute stage.
- req_ready  output  1  LSU can accept a request.
- mem_r_en  input  1  load request.
- mem_w_en  input  1  store request.
- mem_addr  input  ISA_WIDTH  byte address.
- mem_w  input  ISA_WIDTH  store data, LSB-justified.
- mem_size  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- mem_unsigned  input  1  zero-extend load data when 1.
- resp_valid  output  1  one-cycle pulse: access complete.
- mem_r  output  ISA_WIDTH  extended load data; 0 for stores and errors.
- resp_err  output  1  misalignment or timeout; valid with resp_valid.
- bus_req_valid  output  1  bus request.
- bus_req_ready  input  1  bus accepts request.
- bus_we  output  1  write request.
- bus_addr  output  ISA_WIDTH  word-aligned address (mem_addr with [1:0] forced to 0).
- bus_wdata  output  ISA_WIDTH  store data shifted to byte lane.
- bus_wstrb  output  4  byte-lane strobes.
- bus_resp_valid  input  1  bus response.
- bus_rdata  input  ISA_WIDTH  raw read word.

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE.
  - All outputs are 0 except req_ready, which is 1.
  - Timeout counter is cleared.
- States:
  - IDLE: req_ready=1.
  - REQ: bus_req_valid=1.
  - WAIT: waiting for the bus response.
  - RESP: resp_valid=1 for exactly one cycle.
- Request acceptance (IDLE, req_valid=1):
  - addr, wdata, size, unsigned and we=mem_w_en are latched.
  - If neither mem_r_en nor mem_w_en is set: no bus access; go to RESP with mem_r=0, resp_err=0.
  - If both are set: treat as store.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0, or size=3): no bus access; go to RESP with resp_err=1, mem_r=0.
  - Otherwise go to REQ.
- REQ: bus outputs are held stable until bus_req_ready=1, then go to WAIT. The bus request is not retracted while waiting.
- WAIT: on bus_resp_valid, latch bus_rdata and go to RESP.
  - bus_resp_valid in the same cycle as the REQ handshake is ignored; a response is accepted only from WAIT.
- Timeout: counter runs in REQ and WAIT and resets on entry to REQ. When it reaches TIMEOUT, go to RESP with resp_err=1, mem_r=0.
- RESP: drive outputs for one cycle, then IDLE. req_ready=0 in every state except IDLE; there is no back-to-back acceptance. Minimum latency from acceptance to resp_valid is 3 cycles with bus ready and a response one cycle later.
- Store lanes (off = addr[1:0]):
  - byte: wstrb = 1<<off; wdata = {4{w[7:0]}}.
  - half: wstrb = 3<<off; wdata = {2{w[15:0]}}.
  - word: wstrb = 4'hF; wdata = w.
  - Loads: wstrb=0.
- Load extract:
  - byte lane rdata[8*off+:8]; half lane rdata[8*off+:16].
  - Sign-extended unless mem_unsigned=1; word is passed through.
- mem_r and resp_err are registered and hold their value only during RESP; 0 otherwise.
- Reset mid-transaction aborts it immediately, with no response pulse. Bus responses arriving in IDLE are ignored.

Test Plan:
- Word store:
  - Stimulus: addr=0x80000004, w=0xDEADBEEF, size=2, bus ready immediately.
  - Response: bus_addr=0x80000004, wstrb=F, wdata=0xDEADBEEF; resp_valid 3 cycles after acceptance, resp_err=0.
- Byte store at offset 3:
  - Stimulus: w=0x000000AB.
  - Response: wstrb=8, wdata=0xABABABAB, bus_addr with [1:0]=0.
- Signed byte load:
  - Stimulus: addr off=2, rdata=0x11F02233.
  - Response: mem_r=0xFFFFFFF0; with mem_unsigned=1, mem_r=0x000000F0.
- Halfword load:
  - Stimulus: off=2, rdata=0x8001_1234, signed.
  - Response: mem_r=0xFFFF8001.
  - Stimulus: same with off=1.
  - Response: resp_err=1, no bus_req_valid.
- Bus stall and timeout:
  - Stimulus: bus_req_ready held low 5 cycles.
  - Response: bus_req_valid and outputs stable, then normal completion.
  - Stimulus: no bus_resp_valid.
  - Response: resp_err=1 after TIMEOUT cycles.
- Reset during WAIT:
  - Stimulus: rst low in WAIT.
  - Response: immediate IDLE, req_ready=1, bus_req_valid=0, no resp_valid.
  - Stimulus: late bus_resp_valid after reset.
  - Response: ignored.
